bus_decoder_n: RTL and testbench



---
 rtl/bus_decoder_n.sv | 163 ++++++++++++++++
 tb/tb_bus_decoder_n.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_decoder_n.sv
// N-slave address decoder/router: one master, NUM_SLAVES memory-mapped slaves,
// one outstanding transaction, error responses for decode misses and timeouts.
//
// state | meaning
// IDLE  | ready for a master request, decode on accept
// REQ   | request presented to slave sel, waiting for s_req_ready
// WAIT  | request accepted by slave, waiting for s_rsp_valid
// RESP  | one-cycle response to the master
module bus_decoder_n #(
   parameter int NUM_SLAVES = 2,
   parameter int ADDR_W     = 30,
   parameter int DATA_W     = 32,
   parameter logic [NUM_SLAVES*ADDR_W-1:0] BASES     = '0,
   parameter logic [NUM_SLAVES*6-1:0]      LOG_SIZES = '0,
   parameter int TIMEOUT    = 255
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     m_req_valid,
   output logic                     m_req_ready,
   input  logic [ADDR_W-1:0]        m_addr,
   input  logic                     m_we,
   input  logic [DATA_W-1:0]        m_wdata,
   input  logic [DATA_W/8-1:0]      m_wstrb,
   output logic                     m_rsp_valid,
   output logic [DATA_W-1:0]        m_rsp_rdata,
   output logic                     m_rsp_err,
   output logic [NUM_SLAVES-1:0]    s_req_valid,
   input  logic [NUM_SLAVES-1:0]    s_req_ready,
   output logic [ADDR_W-1:0]        s_addr,
   output logic                     s_we,
   output logic [DATA_W-1:0]        s_wdata,
   output logic [DATA_W/8-1:0]      s_wstrb,
   input  logic [NUM_SLAVES-1:0]    s_rsp_valid,
   input  logic [NUM_SLAVES*DATA_W-1:0] s_rsp_rdata,
   input  logic [NUM_SLAVES-1:0]    s_rsp_err,
   output logic                     err_pulse,
   output logic                     err_timeout,
   output logic [ADDR_W-1:0]        err_addr
);

   localparam int SEL_W   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam int TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   state_t             state, state_nxt;
   logic [SEL_W-1:0]   sel, sel_q;
   logic               hit;
   logic [CNT_W-1:0]   cnt;
   logic               err_q, to_q;
   logic [DATA_W-1:0]  rdata_q;
   logic               capture, timeout_hit, resp_now, tmo_reached;
   logic [5:0]         lg;

   // Descending scan so the lowest hitting index is the one that sticks.
   always_comb begin
      hit = 1'b0;
      sel = '0;
      lg  = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         lg = LOG_SIZES[i*6 +: 6];
         if ((int'(lg) >= ADDR_W) ||
             ((m_addr >> lg) == (BASES[i*ADDR_W +: ADDR_W] >> lg))) begin
            hit = 1'b1;
            sel = SEL_W'(i);
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      capture     = 1'b0;
      timeout_hit = 1'b0;
      resp_now    = s_rsp_valid[sel_q];
      tmo_reached = (TIMEOUT != 0) && (cnt == CNT_W'(TO_LAST));
      case (state)
         IDLE: if (m_req_valid) state_nxt = hit ? REQ : RESP;
         REQ: begin
            if (s_req_ready[sel_q] && resp_now) begin
               capture   = 1'b1;
               state_nxt = RESP;
            end else if (tmo_reached) begin
               timeout_hit = 1'b1;
               state_nxt   = RESP;
            end else if (s_req_ready[sel_q]) begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (resp_now) begin
               capture   = 1'b1;
               state_nxt = RESP;
            end else if (tmo_reached) begin
               timeout_hit = 1'b1;
               state_nxt   = RESP;
            end
         end
         RESP: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         sel_q    <= '0;
         cnt      <= '0;
         err_q    <= 1'b0;
         to_q     <= 1'b0;
         rdata_q  <= '0;
         err_addr <= '0;
         s_addr   <= '0;
         s_we     <= 1'b0;
         s_wdata  <= '0;
         s_wstrb  <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && m_req_valid) begin
            s_addr  <= m_addr;
            s_we    <= m_we;
            s_wdata <= m_wdata;
            s_wstrb <= m_wstrb;
            sel_q   <= sel;
            cnt     <= '0;
            if (!hit) begin
               err_q    <= 1'b1;
               to_q     <= 1'b0;
               rdata_q  <= '0;
               err_addr <= m_addr;
            end
         end
         if (state == REQ || state == WAIT) begin
            cnt <= cnt + 1'b1;
            if (capture) begin
               err_q   <= s_rsp_err[sel_q];
               to_q    <= 1'b0;
               rdata_q <= s_rsp_err[sel_q] ? '0 : s_rsp_rdata[int'(sel_q)*DATA_W +: DATA_W];
               if (s_rsp_err[sel_q]) err_addr <= s_addr;
            end else if (timeout_hit) begin
               err_q    <= 1'b1;
               to_q     <= 1'b1;
               rdata_q  <= '0;
               err_addr <= s_addr;
            end
         end
      end
   end

   always_comb begin
      s_req_valid = '0;
      if (state == REQ) s_req_valid[sel_q] = 1'b1;
   end

   assign m_req_ready = (state == IDLE) && !rst;
   assign m_rsp_valid = (state == RESP);
   assign m_rsp_err   = m_rsp_valid & err_q;
   assign m_rsp_rdata = rdata_q;
   assign err_pulse   = m_rsp_valid & err_q;
   assign err_timeout = m_rsp_valid & err_q & to_q;

endmodule

// File: tb/tb_bus_decoder_n.sv
// Directed bench for bus_decoder_n: two slaves (4K words at 0, 1K words at 0x1000),
// TIMEOUT=8, checks hits, misses, slave errors, timeouts and mid-transaction reset.
module tb_bus_decoder_n;
   localparam int NS = 2, AW = 30, DW = 32;

   logic            clk = 1'b0, rst = 1'b1;
   logic            m_req_valid = 1'b0, m_req_ready;
   logic [AW-1:0]   m_addr = '0;
   logic            m_we = 1'b0;
   logic [DW-1:0]   m_wdata = '0;
   logic [3:0]      m_wstrb = '0;
   logic            m_rsp_valid, m_rsp_err;
   logic [DW-1:0]   m_rsp_rdata;
   logic [NS-1:0]   s_req_valid;
   logic [NS-1:0]   s_req_ready = '0;
   logic [AW-1:0]   s_addr;
   logic            s_we;
   logic [DW-1:0]   s_wdata;
   logic [3:0]      s_wstrb;
   logic [NS-1:0]   s_rsp_valid = '0;
   logic [NS*DW-1:0] s_rsp_rdata = '0;
   logic [NS-1:0]   s_rsp_err = '0;
   logic            err_pulse, err_timeout;
   logic [AW-1:0]   err_addr;

   int n_cmp = 0, n_bad = 0;

   bus_decoder_n #(
      .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW),
      .BASES({30'h0001000, 30'h0000000}),
      .LOG_SIZES({6'd10, 6'd12}),
      .TIMEOUT(8)
   ) dut (
      .clk(clk), .rst(rst),
      .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
      .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_rsp_valid(m_rsp_valid), .m_rsp_rdata(m_rsp_rdata), .m_rsp_err(m_rsp_err),
      .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
      .s_addr(s_addr), .s_we(s_we), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .s_rsp_valid(s_rsp_valid), .s_rsp_rdata(s_rsp_rdata), .s_rsp_err(s_rsp_err),
      .err_pulse(err_pulse), .err_timeout(err_timeout), .err_addr(err_addr)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(); step();
      n_cmp++; if (m_req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", m_req_ready); end
      n_cmp++; if (m_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", m_rsp_valid); end
      n_cmp++; if (s_req_valid !== 2'b00) begin n_bad++; $display("FAIL reset_s_req_valid: got %b want 00", s_req_valid); end
      n_cmp++; if (err_addr !== 30'h0) begin n_bad++; $display("FAIL reset_err_addr: got %h want 0", err_addr); end
      n_cmp++; if (m_rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", m_rsp_rdata); end
      rst = 1'b0;
      #1;
      n_cmp++; if (m_req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready: got %b want 1", m_req_ready); end
   endtask

   task automatic test_read();
      m_req_valid = 1'b1; m_addr = 30'h0000010; m_we = 1'b0;
      step();
      m_req_valid = 1'b0;
      n_cmp++; if (s_req_valid !== 2'b01) begin n_bad++; $display("FAIL read_s_req_valid: got %b want 01", s_req_valid); end
      n_cmp++; if (s_addr !== 30'h0000010) begin n_bad++; $display("FAIL read_s_addr: got %h want 10", s_addr); end
      n_cmp++; if (m_req_ready !== 1'b0) begin n_bad++; $display("FAIL read_busy_ready: got %b want 0", m_req_ready); end
      s_req_ready = 2'b01;
      step();
      s_req_ready = 2'b00; s_rsp_valid = 2'b01; s_rsp_rdata = {32'h11111111, 32'hDEADBEEF};
      n_cmp++; if (s_req_valid !== 2'b00) begin n_bad++; $display("FAIL read_wait_s_req_valid: got %b want 00", s_req_valid); end
      n_cmp++; if (m_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL read_early_rsp: got %b want 0", m_rsp_valid); end
      step();
      s_rsp_valid = 2'b00;
      n_cmp++; if (m_rsp_valid !== 1'b1) begin n_bad++; $display("FAIL read_rsp_valid_t3: got %b want 1", m_rsp_valid); end
      n_cmp++; if (m_rsp_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL read_rdata: got %h want deadbeef", m_rsp_rdata); end
      n_cmp++; if (m_rsp_err !== 1'b0) begin n_bad++; $display("FAIL read_err: got %b want 0", m_rsp_err); end
      n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL read_err_pulse: got %b want 0", err_pulse); end
      step();
      n_cmp++; if (m_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL read_rsp_one_cycle: got %b want 0", m_rsp_valid); end
      n_cmp++; if (m_rsp_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL read_rdata_hold: got %h want deadbeef", m_rsp_rdata); end
      n_cmp++; if (m_req_ready !== 1'b1) begin n_bad++; $display("FAIL read_idle_ready: got %b want 1", m_req_ready); end
   endtask

   task automatic test_write();
      m_req_valid = 1'b1; m_addr = 30'h0001004; m_we = 1'b1; m_wdata = 32'h12345678; m_wstrb = 4'h3;
      step();
      m_req_valid = 1'b0; m_we = 1'b0; m_wdata = '0; m_wstrb = '0;
      n_cmp++; if (s_req_valid !== 2'b10) begin n_bad++; $display("FAIL write_s_req_valid: got %b want 10", s_req_valid); end
      n_cmp++; if (s_addr !== 30'h0001004) begin n_bad++; $display("FAIL write_s_addr: got %h want 1004", s_addr); end
      n_cmp++; if (s_we !== 1'b1) begin n_bad++; $display("FAIL write_s_we: got %b want 1", s_we); end
      n_cmp++; if (s_wdata !== 32'h12345678) begin n_bad++; $display("FAIL write_s_wdata: got %h want 12345678", s_wdata); end
      n_cmp++; if (s_wstrb !== 4'h3) begin n_bad++; $display("FAIL write_s_wstrb: got %h want 3", s_wstrb); end
      s_req_ready = 2'b10; s_rsp_valid = 2'b10; s_rsp_rdata = {32'hCAFE0001, 32'h0};
      step();
      s_req_ready = 2'b00; s_rsp_valid = 2'b00;
      n_cmp++; if (m_rsp_valid !== 1'b1) begin n_bad++; $display("FAIL write_rsp_valid_t2: got %b want 1", m_rsp_valid); end
      n_cmp++; if (m_rsp_err !== 1'b0) begin n_bad++; $display("FAIL write_err: got %b want 0", m_rsp_err); end
      n_cmp++; if (m_rsp_rdata !== 32'hCAFE0001) begin n_bad++; $display("FAIL write_rdata: got %h want cafe0001", m_rsp_rdata); end
      step();
   endtask

   task automatic test_miss();
      m_req_valid = 1'b1; m_addr = 30'h0002000;
      step();
      m_req_valid = 1'b0;
      n_cmp++; if (s_req_valid !== 2'b00) begin n_bad++; $display("FAIL miss_s_req_valid: got %b want 00", s_req_valid); end
      n_cmp++; if (m_rsp_valid !== 1'b1) begin n_bad++; $display("FAIL miss_rsp_valid_t1: got %b want 1", m_rsp_valid); end
      n_cmp++; if (m_rsp_err !== 1'b1) begin n_bad++; $display("FAIL miss_err: got %b want 1", m_rsp_err); end
      n_cmp++; if (m_rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL miss_rdata: got %h want 0", m_rsp_rdata); end
      n_cmp++; if (err_pulse !== 1'b1) begin n_bad++; $display("FAIL miss_err_pulse: got %b want 1", err_pulse); end
      n_cmp++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL miss_err_timeout: got %b want 0", err_timeout); end
      n_cmp++; if (err_addr !== 30'h0002000) begin n_bad++; $display("FAIL miss_err_addr: got %h want 2000", err_addr); end
      step();
      n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL miss_pulse_width: got %b want 0", err_pulse); end
   endtask

   task automatic test_timeout();
      m_req_valid = 1'b1; m_addr = 30'h0001010;
      step();
      m_req_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         n_cmp++; if (m_rsp_valid !== 1'b0 || s_req_valid !== 2'b10) begin
            n_bad++; $display("FAIL timeout_pending_c%0d: got rsp=%b sreq=%b want rsp=0 sreq=10", k, m_rsp_valid, s_req_valid);
         end
         step();
      end
      n_cmp++; if (m_rsp_valid !== 1'b1) begin n_bad++; $display("FAIL timeout_rsp_valid: got %b want 1", m_rsp_valid); end
      n_cmp++; if (m_rsp_err !== 1'b1) begin n_bad++; $display("FAIL timeout_err: got %b want 1", m_rsp_err); end
      n_cmp++; if (err_timeout !== 1'b1) begin n_bad++; $display("FAIL timeout_flag: got %b want 1", err_timeout); end
      n_cmp++; if (err_addr !== 30'h0001010) begin n_bad++; $display("FAIL timeout_err_addr: got %h want 1010", err_addr); end
      n_cmp++; if (s_req_valid !== 2'b00) begin n_bad++; $display("FAIL timeout_s_req_drop: got %b want 00", s_req_valid); end
      step(); step(); step();
      s_rsp_valid = 2'b10; s_rsp_rdata = {32'hBAD0BAD0, 32'h0};
      for (int k = 0; k < 3; k++) begin
         step();
         s_rsp_valid = 2'b00;
         n_cmp++; if (m_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL timeout_late_rsp_c%0d: got %b want 0", k, m_rsp_valid); end
      end
   endtask

   task automatic test_slave_err();
      m_req_valid = 1'b1; m_addr = 30'h0000020;
      step();
      m_req_valid = 1'b0;
      s_req_ready = 2'b01; s_rsp_valid = 2'b10; s_rsp_err = 2'b10;
      step();
      s_req_ready = 2'b00;
      n_cmp++; if (m_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL serr_foreign_rsp: got %b want 0", m_rsp_valid); end
      s_rsp_valid = 2'b11; s_rsp_err = 2'b01; s_rsp_rdata = {32'h77777777, 32'h00000055};
      step();
      s_rsp_valid = 2'b00; s_rsp_err = 2'b00;
      n_cmp++; if (m_rsp_valid !== 1'b1 || m_rsp_err !== 1'b1) begin n_bad++; $display("FAIL serr_rsp: got valid=%b err=%b want 1 1", m_rsp_valid, m_rsp_err); end
      n_cmp++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL serr_timeout: got %b want 0", err_timeout); end
      n_cmp++; if (err_pulse !== 1'b1) begin n_bad++; $display("FAIL serr_pulse: got %b want 1", err_pulse); end
      n_cmp++; if (m_rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL serr_rdata: got %h want 0", m_rsp_rdata); end
      n_cmp++; if (err_addr !== 30'h0000020) begin n_bad++; $display("FAIL serr_err_addr: got %h want 20", err_addr); end
      step();
   endtask

   task automatic test_reset_mid();
      m_req_valid = 1'b1; m_addr = 30'h0000030; m_we = 1'b1; m_wdata = 32'hA5A5A5A5; m_wstrb = 4'hF;
      step();
      m_req_valid = 1'b0;
      s_req_ready = 2'b01;
      step();
      s_req_ready = 2'b00;
      rst = 1'b1;
      step();
      n_cmp++; if (m_rsp_valid !== 1'b0 || s_req_valid !== 2'b00 || m_req_ready !== 1'b0) begin
         n_bad++; $display("FAIL rstmid_ctrl: got rsp=%b sreq=%b rdy=%b want 0 00 0", m_rsp_valid, s_req_valid, m_req_ready);
      end
      n_cmp++; if (s_addr !== 30'h0 || s_we !== 1'b0 || s_wdata !== 32'h0 || s_wstrb !== 4'h0) begin
         n_bad++; $display("FAIL rstmid_cmd: got addr=%h we=%b wdata=%h wstrb=%h want all 0", s_addr, s_we, s_wdata, s_wstrb);
      end
      n_cmp++; if (err_addr !== 30'h0) begin n_bad++; $display("FAIL rstmid_err_addr: got %h want 0", err_addr); end
      rst = 1'b0;
      s_rsp_valid = 2'b01; s_rsp_rdata = {32'h0, 32'h0000ABCD};
      #1;
      n_cmp++; if (m_req_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready: got %b want 1", m_req_ready); end
      for (int k = 0; k < 2; k++) begin
         step();
         s_rsp_valid = 2'b00;
         n_cmp++; if (m_rsp_valid !== 1'b0 || m_rsp_rdata !== 32'h0) begin
            n_bad++; $display("FAIL rstmid_dropped_c%0d: got rsp=%b rdata=%h want 0 0", k, m_rsp_valid, m_rsp_rdata);
         end
      end
   endtask

   task automatic test_back_to_back();
      int pulses;
      pulses = 0;
      m_req_valid = 1'b1; m_addr = 30'h0002000;
      step();
      n_cmp++; if (m_req_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_in_resp: got %b want 0", m_req_ready); end
      for (int k = 0; k < 4; k++) begin
         if (m_rsp_valid === 1'b1) pulses++;
         step();
      end
      m_req_valid = 1'b0;
      n_cmp++; if (pulses !== 2) begin n_bad++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
      step(); step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_read();
      test_write();
      test_miss();
      test_timeout();
      test_slave_err();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
